// File: rtl/sram_dport_arbiter.sv
// Two-master round-robin arbiter for the SRAM data port with bounded hold,
// registered grants and a one-cycle read-return qualifier per master.
module sram_dport_arbiter #(
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_bwe,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_bwe,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_bwe,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned HOLD_W = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN0 = 2'd1,
        S_OWN1 = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last_owner;
    logic                w_last_owner_nxt;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [HOLD_W-1:0]   w_hold_nxt;
    logic                r_rd_pend0;
    logic                r_rd_pend1;
    logic [ADDR_W-1:0]   r_addr_q;
    logic [31:0]         r_wdata_q;

    logic                w_acc0;
    logic                w_acc1;
    logic                w_acc;
    logic                w_own_req;
    logic                w_oth_req;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [31:0]         w_sel_wdata;
    logic [3:0]          w_sel_bwe;

    // Grants are a pure decode of the registered state.
    assign m0_gnt = (r_state == S_OWN0);
    assign m1_gnt = (r_state == S_OWN1);

    assign w_acc0 = m0_gnt && m0_req;
    assign w_acc1 = m1_gnt && m1_req;
    assign w_acc  = w_acc0 || w_acc1;

    assign w_own_req = (r_state == S_OWN1) ? m1_req : m0_req;
    assign w_oth_req = (r_state == S_OWN1) ? m0_req : m1_req;

    assign w_sel_addr  = w_acc1 ? m1_addr  : m0_addr;
    assign w_sel_wdata = w_acc1 ? m1_wdata : m0_wdata;
    assign w_sel_bwe   = w_acc1 ? m1_bwe   : m0_bwe;

    // Non-accepted cycles replay the last address/data with writes masked off.
    assign mem_addr  = w_acc ? w_sel_addr  : r_addr_q;
    assign mem_wdata = w_acc ? w_sel_wdata : r_wdata_q;
    assign mem_bwe   = w_acc ? w_sel_bwe   : 4'b0000;

    assign rdata     = mem_rdata;
    assign m0_rvalid = r_rd_pend0;
    assign m1_rvalid = r_rd_pend1;

    always_comb begin
        w_state_nxt      = r_state;
        w_last_owner_nxt = r_last_owner;
        w_hold_nxt       = r_hold_cnt;
        case (r_state)
            S_IDLE: begin
                w_hold_nxt = '0;
                if (m0_req && (!m1_req || r_last_owner)) begin
                    w_state_nxt = S_OWN0;
                end else if (m1_req) begin
                    w_state_nxt = S_OWN1;
                end
            end
            S_OWN0, S_OWN1: begin
                if (!w_own_req || (w_oth_req && (r_hold_cnt == HOLD_LAST))) begin
                    w_last_owner_nxt = (r_state == S_OWN1);
                    w_hold_nxt       = '0;
                    if (w_oth_req) begin
                        w_state_nxt = (r_state == S_OWN0) ? S_OWN1 : S_OWN0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (r_hold_cnt != HOLD_LAST) begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_owner <= 1'b1;
            r_hold_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_hold_cnt   <= w_hold_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pend0 <= 1'b0;
            r_rd_pend1 <= 1'b0;
            r_addr_q   <= '0;
            r_wdata_q  <= '0;
        end else begin
            r_rd_pend0 <= w_acc0 && (m0_bwe == 4'b0000);
            r_rd_pend1 <= w_acc1 && (m1_bwe == 4'b0000);
            if (w_acc) begin
                r_addr_q  <= w_sel_addr;
                r_wdata_q <= w_sel_wdata;
            end
        end
    end

endmodule

// File: tb/tb_sram_dport_arbiter.sv
// Scoreboard bench for sram_dport_arbiter: behavioural SRAM plus a shadow
// memory supplying expected read data, queued per master at issue time.
module tb_sram_dport_arbiter;

    localparam int unsigned ADDR_W   = 14;
    localparam int unsigned MAX_HOLD = 8;
    localparam int unsigned DEPTH    = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              m0_req, m1_req;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [31:0]       m0_wdata, m1_wdata;
    logic [3:0]        m0_bwe, m1_bwe;
    logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0]       rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_bwe;
    logic [31:0]       mem_rdata;

    logic [31:0] sram   [DEPTH];
    logic [31:0] shadow [DEPTH];
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    bit          acc_log[$];
    bit          log_en;
    int          n_vec, n_miss;
    int          acc0, rv0;

    sram_dport_arbiter #(.ADDR_W(ADDR_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_bwe(m0_bwe),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_bwe(m1_bwe),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_bwe(mem_bwe), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read SRAM with byte write enables.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_bwe[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        mem_rdata <= sram[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check_eq("gnt_mutex", 32'(m0_gnt && m1_gnt), 32'd0);
            if (m0_gnt && m0_req) begin
                acc0++;
                if (log_en) acc_log.push_back(1'b0);
            end
            if (m1_gnt && m1_req && log_en) acc_log.push_back(1'b1);
            if (m0_rvalid) begin
                rv0++;
                if (q0.size() == 0) check_eq("m0_spurious_rvalid", 32'd1, 32'd0);
                else check_eq("m0_rdata", rdata, q0.pop_front());
            end
            if (m1_rvalid) begin
                if (q1.size() == 0) check_eq("m1_spurious_rvalid", 32'd1, 32'd0);
                else check_eq("m1_rdata", rdata, q1.pop_front());
            end
        end
    end

    task automatic shadow_wr(input logic [ADDR_W-1:0] a, input logic [31:0] wd, input logic [3:0] be);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) shadow[a][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue one beat and return just after the edge that accepts it; req stays high.
    task automatic beat(input int m, input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                        input logic [3:0] be);
        bit got;
        if (m == 0) begin
            m0_req = 1'b1; m0_addr = a; m0_wdata = wd; m0_bwe = be;
        end else begin
            m1_req = 1'b1; m1_addr = a; m1_wdata = wd; m1_bwe = be;
        end
        if (be == 4'b0000) begin
            if (m == 0) q0.push_back(shadow[a]);
            else        q1.push_back(shadow[a]);
        end else begin
            shadow_wr(a, wd, be);
        end
        got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            got = (m == 0) ? m0_gnt : m1_gnt;
        end
        if (!got) begin
            check_eq("gnt_timeout", 32'(m), 32'hFFFF_FFFF);
            return;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int m);
        if (m == 0) begin m0_req = 1'b0; m0_bwe = 4'b0000; end
        else        begin m1_req = 1'b0; m1_bwe = 4'b0000; end
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1 rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, start;
        bit seen;
        n_vec = 0; n_miss = 0; acc0 = 0; rv0 = 0; log_en = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            sram[i]   = 32'hC0DE_0000 | 32'(i);
            shadow[i] = 32'hC0DE_0000 | 32'(i);
        end
        sram[16'h010]   = 32'hDEAD_BEEF;
        shadow[16'h010] = 32'hDEAD_BEEF;

        // Reset with m0 write request held high
        rst = 1'b1;
        m0_req = 1'b1; m0_addr = ADDR_W'(32'h030); m0_wdata = 32'hA5A5_0001; m0_bwe = 4'hF;
        m1_req = 1'b0; m1_addr = '0; m1_wdata = '0; m1_bwe = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        check_eq("rst_m1_gnt", 32'(m1_gnt), 32'd0);
        check_eq("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
        check_eq("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
        check_eq("rst_mem_bwe", 32'(mem_bwe), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rel_idle_m0_gnt", 32'(m0_gnt), 32'd0);
        @(negedge clk);
        check_eq("rel_m0_gnt", 32'(m0_gnt), 32'd1);
        check_eq("rel_mem_bwe", 32'(mem_bwe), 32'hF);
        check_eq("rel_mem_addr", 32'(mem_addr), 32'h030);
        check_eq("rel_mem_wdata", mem_wdata, 32'hA5A5_0001);
        shadow_wr(ADDR_W'(32'h030), 32'hA5A5_0001, 4'hF);
        @(posedge clk);
        #1 idle(0);
        wait_cycles(2);

        // Single m0 read of a known word, then read back the reset-time write
        base = rv0;
        beat(0, ADDR_W'(32'h010), 32'h0, 4'h0);
        idle(0);
        wait_cycles(3);
        check_eq("single_rd_count", 32'(rv0 - base), 32'd1);
        beat(0, ADDR_W'(32'h030), 32'h0, 4'h0);
        idle(0);
        wait_cycles(2);

        // Partial write by m1, read back by m0
        beat(1, ADDR_W'(32'h020), 32'h1234_5678, 4'b0011);
        idle(1);
        wait_cycles(2);
        beat(0, ADDR_W'(32'h020), 32'h0, 4'h0);
        idle(0);
        wait_cycles(3);
        check_eq("partial_wr_word", sram[16'h020], 32'hC0DE_5678);

        // Both masters stream reads from IDLE after reset: 8-beat alternation
        reset_dut();
        log_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 24; i++) beat(0, ADDR_W'(32'h100 + i), 32'h0, 4'h0);
                idle(0);
            end
            begin
                for (int i = 0; i < 24; i++) beat(1, ADDR_W'(32'h200 + i), 32'h0, 4'h0);
                idle(1);
            end
        join
        wait_cycles(4);
        log_en = 1'b0;
        check_eq("arb_log_len", 32'(acc_log.size()), 32'd48);
        for (int i = 0; i < acc_log.size(); i++) begin
            check_eq($sformatf("arb_owner_%0d", i), 32'(acc_log[i]), 32'((i / MAX_HOLD) % 2));
        end

        // m0 streams 20 reads; m1 joins after 12 accepted m0 beats
        base = rv0;
        start = acc0;
        fork
            begin
                for (int i = 0; i < 20; i++) beat(0, ADDR_W'(32'h300 + i), 32'h0, 4'h0);
                idle(0);
            end
            begin
                seen = 1'b0;
                for (int n = 0; n < 200 && !seen; n++) begin
                    @(negedge clk);
                    seen = (acc0 - start) >= 12;
                end
                check_eq("m0_stream_12_seen", 32'(seen), 32'd1);
                @(posedge clk);
                #1;
                start = acc0;
                beat(1, ADDR_W'(32'h310), 32'h0, 4'h0);
                idle(1);
                check_eq("m1_preempt_le_hold", 32'((acc0 - start) <= int'(MAX_HOLD)), 32'd1);
            end
        join
        wait_cycles(3);
        check_eq("stream_rvalid_count", 32'(rv0 - base), 32'd20);

        // Reset while m1 owns the port with a read pending
        beat(1, ADDR_W'(32'h040), 32'h0, 4'h0);
        rst = 1'b1;
        m1_addr = ADDR_W'(32'h040); m1_wdata = 32'hBAD0_BAD0; m1_bwe = 4'hF;
        @(negedge clk);
        check_eq("midrst_m1_rvalid", 32'(m1_rvalid), 32'd0);
        check_eq("midrst_mem_bwe", 32'(mem_bwe), 32'd0);
        check_eq("midrst_m1_gnt", 32'(m1_gnt), 32'd0);
        q1.delete();
        @(posedge clk);
        #1;
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_idle_m0_gnt", 32'(m0_gnt), 32'd0);
        check_eq("midrst_idle_m1_gnt", 32'(m1_gnt), 32'd0);
        @(posedge clk);
        #1;
        beat(0, ADDR_W'(32'h040), 32'h0, 4'h0);
        idle(0);
        wait_cycles(3);

        check_eq("q0_drained", 32'(q0.size()), 32'd0);
        check_eq("q1_drained", 32'(q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
